// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Shares one output channel between N requesters through a wide N:1 data
//   mux. Each requester and the output use a valid/ready handshake. A
//   round-robin arbiter picks a requester in IDLE, registers a one-hot grant,
//   and then routes data, last flag and handshake through the mux in GRANT.
//   There is a one-cycle arbitration bubble between packets.
//
// Optional feature macro: ARB_BURST_LOCK_EN
//   defined   : a packet ends on a transfer with in_last[g]=1, so the grant is
//               held over multi-beat packets.
//   undefined : every transfer is a packet. in_last is only passed through to
//               out_last, and the grant is released after every transfer.
//
// Parameters
//   N          number of requesters (2..16)
//   W          data width per requester
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   in_valid   per-requester valid
//   in_data    requester k data in bits [k*W +: W]
//   in_last    per-requester end-of-packet flag
//   in_ready   per-requester ready (only the granted bit can be set)
//   out_valid  muxed valid
//   out_data   muxed data (0 when not granting)
//   out_last   muxed last flag (0 when not granting)
//   out_ready  consumer ready
//   grant      one-hot current grant, all zero when idle
//   busy       high while a grant is held

module mux_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    input  logic           out_ready,
    output logic [N-1:0]   grant,
    output logic           busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  grant_q;
    logic [N-1:0]  grant_next;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_next;
    logic [IW-1:0] gidx;
    logic [IW-1:0] gidx_next;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          xfer;
    logic          pkt_end;

    // Round-robin search: the first valid requester after the last winner,
    // wrapping modulo N. ptr starts at N-1 so requester 0 has first priority.
    always_comb begin : rr_search
        int cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(ptr) + i) % N;
            if (!pick_found && in_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(cand);
            end
        end
    end

    // Output mux and handshake routing. Everything here is combinational from
    // the registered grant index plus inputs, so data latency is zero while a
    // grant is held; outside GRANT the channel is forced quiet.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        in_ready  = '0;
        if (state == GRANT) begin
            out_valid      = in_valid[gidx];
            out_data       = in_data[int'(gidx)*W +: W];
            out_last       = in_last[gidx];
            in_ready[gidx] = out_ready;
        end
    end

    assign xfer = out_valid & out_ready;

`ifdef ARB_BURST_LOCK_EN
    // Hold the grant until the beat carrying the end-of-packet flag moves.
    assign pkt_end = xfer & in_last[gidx];
`else
    // Every beat is its own packet, so any transfer releases the grant.
    assign pkt_end = xfer;
`endif

    // Next-state logic: IDLE registers a fresh one-hot grant when anybody is
    // requesting; GRANT releases it at the end of a packet and remembers the
    // winner so the next search starts just after it. A request that arrives
    // alongside the end of packet is picked up in the following IDLE cycle.
    always_comb begin
        state_next = state;
        grant_next = grant_q;
        ptr_next   = ptr;
        gidx_next  = gidx;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next = GRANT;
                    grant_next = N'(1) << pick_idx;
                    gidx_next  = pick_idx;
                end
            end
            GRANT: begin
                if (pkt_end) begin
                    state_next = IDLE;
                    grant_next = '0;
                    ptr_next   = gidx;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // State registers. Reset aborts any packet in flight without flushing and
    // restores the pointer so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr     <= IW'(N - 1);
            gidx    <= '0;
        end else begin
            state   <= state_next;
            grant_q <= grant_next;
            ptr     <= ptr_next;
            gidx    <= gidx_next;
        end
    end

    assign grant = grant_q;
    assign busy  = (state == GRANT);

endmodule
